// File: rtl/note_player.sv
// Note player: latches notes from the song reader, times their duration in beats and
// steps a phase accumulator that addresses the waveform ROM on codec requests.
module note_player #(
    parameter int unsigned PHASE_W = 20,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               new_note,
    input  logic [5:0]         note,
    input  logic [5:0]         duration,
    input  logic               beat,
    input  logic               generate_next,
    input  logic [PHASE_W-1:0] step_size,
    output logic [5:0]         note_q,
    output logic               note_active,
    output logic [ADDR_W-1:0]  sample_addr,
    output logic               sample_valid,
    output logic               note_done
);

    typedef enum logic {StIdle, StPlaying} state_e;

    state_e             state_q, state_d;
    logic [5:0]         note_d;
    logic [5:0]         duration_q, duration_d;
    logic [5:0]         beat_cnt_q, beat_cnt_d;
    logic [5:0]         beat_next;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               step_ok_q, step_ok_d;
    logic               note_done_q, note_done_d;
    logic               sample_valid_q;

    assign beat_next = beat_cnt_q + 6'd1;

    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        duration_d  = duration_q;
        beat_cnt_d  = beat_cnt_q;
        phase_d     = phase_q;
        // step_ok lags acceptance by one cycle to cover the frequency ROM latency
        step_ok_d   = 1'b1;
        note_done_d = 1'b0;

        if (new_note) begin
            // A new note overrides any completion of the current one in the same cycle
            note_d     = note;
            duration_d = duration;
            beat_cnt_d = 6'd0;
            phase_d    = '0;
            step_ok_d  = 1'b0;
            if (duration == 6'd0) begin
                state_d     = StIdle;
                note_done_d = 1'b1;
            end else begin
                state_d = StPlaying;
            end
        end else if (state_q == StPlaying && play) begin
            if (note_q != 6'd0 && step_ok_q && generate_next) begin
                phase_d = phase_q + step_size;
            end
            if (beat) begin
                beat_cnt_d = beat_next;
                if (beat_next == duration_q) begin
                    beat_cnt_d  = 6'd0;
                    note_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            note_q         <= 6'd0;
            duration_q     <= 6'd0;
            beat_cnt_q     <= 6'd0;
            phase_q        <= '0;
            step_ok_q      <= 1'b0;
            note_done_q    <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            note_q         <= note_d;
            duration_q     <= duration_d;
            beat_cnt_q     <= beat_cnt_d;
            phase_q        <= phase_d;
            step_ok_q      <= step_ok_d;
            note_done_q    <= note_done_d;
            sample_valid_q <= generate_next;
        end
    end

    assign note_active  = (state_q == StPlaying) && (note_q != 6'd0);
    assign sample_addr  = phase_q[PHASE_W-1 -: ADDR_W];
    assign sample_valid = sample_valid_q;
    assign note_done    = note_done_q;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed vector table, hand-written corner sequences and random
// stimulus checked against a note-level behavioural model.
module tb_note_player;

    localparam int PHASE_W = 20;
    localparam int ADDR_W  = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               play;
    logic               new_note;
    logic [5:0]         note;
    logic [5:0]         duration;
    logic               beat;
    logic               generate_next;
    logic [PHASE_W-1:0] step_size;
    logic [5:0]         note_q;
    logic               note_active;
    logic [ADDR_W-1:0]  sample_addr;
    logic               sample_valid;
    logic               note_done;

    note_player #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .play          (play),
        .new_note      (new_note),
        .note          (note),
        .duration      (duration),
        .beat          (beat),
        .generate_next (generate_next),
        .step_size     (step_size),
        .note_q        (note_q),
        .note_active   (note_active),
        .sample_addr   (sample_addr),
        .sample_valid  (sample_valid),
        .note_done     (note_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: the note being played, beats heard so far, phase as an integer
    bit     m_playing;
    int     m_note, m_dur, m_beats, m_age;
    longint m_phase;
    bit     m_valid, m_done;

    function automatic void model_reset();
        m_playing = 0; m_note = 0; m_dur = 0; m_beats = 0; m_age = 0;
        m_phase = 0; m_valid = 0; m_done = 0;
    endfunction

    function automatic void model_step(bit nn, int n, int d, bit pl, bit bt, bit gn, longint ss);
        m_valid = gn;
        m_done  = 0;
        if (nn) begin
            m_note = n; m_dur = d; m_beats = 0; m_phase = 0; m_age = 0;
            m_playing = (d != 0);
            m_done    = (d == 0);
        end else begin
            // m_age counts cycles since acceptance; the ROM step is usable from age 1
            if (m_playing && pl && m_note != 0 && m_age >= 1 && gn)
                m_phase = (m_phase + ss) % (64'd1 << PHASE_W);
            if (m_playing && pl && bt) begin
                m_beats++;
                if (m_beats == m_dur) begin
                    m_done = 1; m_playing = 0; m_beats = 0;
                end
            end
            if (m_age < 2) m_age++;
        end
    endfunction

    function automatic logic [18:0] dut_vec();
        return {note_q, note_active, sample_addr, sample_valid, note_done};
    endfunction

    function automatic logic [18:0] model_vec();
        logic [5:0] n6;
        logic [9:0] a10;
        n6  = 6'(m_note);
        a10 = 10'(m_phase >> (PHASE_W - ADDR_W));
        return {n6, (m_playing && m_note != 0), a10, m_valid, m_done};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance the model at the edge, compare just after
    task automatic cycle(input bit nn, input logic [5:0] n, input logic [5:0] d, input bit pl,
                         input bit bt, input bit gn, input logic [PHASE_W-1:0] ss);
        @(negedge clk);
        new_note = nn; note = n; duration = d; play = pl; beat = bt;
        generate_next = gn; step_size = ss;
        @(posedge clk);
        model_step(nn, n, d, pl, bt, gn, ss);
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; new_note = 0; note = 0; duration = 0; play = 0; beat = 0;
        generate_next = 0; step_size = 0;
        model_reset();
        @(negedge clk);
        check("reset_state", 32'(dut_vec()), 32'd0);
        reset = 0;
    endtask

    typedef struct {
        bit         nn;
        logic [5:0] n, d;
        bit         pl, bt, gn;
        logic [19:0] ss;
        logic [5:0] e_note;
        bit         e_act;
        logic [9:0] e_addr;
        bit         e_valid, e_done;
    } vec_t;

    vec_t tbl[10];
    int   done_cnt, done_at, beat_no, third_beat;

    initial begin
        // nn note dur play beat gen step | note act addr valid done
        tbl[0] = '{1, 6'd5, 6'd2, 1, 0, 0, 20'h00400, 6'd5, 1, 10'd0, 0, 0};
        tbl[1] = '{0, 6'd0, 6'd0, 1, 0, 1, 20'h00400, 6'd5, 1, 10'd0, 1, 0};
        tbl[2] = '{0, 6'd0, 6'd0, 1, 0, 1, 20'h00400, 6'd5, 1, 10'd1, 1, 0};
        tbl[3] = '{0, 6'd0, 6'd0, 1, 0, 1, 20'h00400, 6'd5, 1, 10'd2, 1, 0};
        tbl[4] = '{0, 6'd0, 6'd0, 1, 1, 1, 20'h00400, 6'd5, 1, 10'd3, 1, 0};
        tbl[5] = '{0, 6'd0, 6'd0, 1, 0, 1, 20'h00400, 6'd5, 1, 10'd4, 1, 0};
        tbl[6] = '{0, 6'd0, 6'd0, 1, 1, 0, 20'h00400, 6'd5, 0, 10'd4, 0, 1};
        tbl[7] = '{0, 6'd0, 6'd0, 1, 0, 1, 20'h00400, 6'd5, 0, 10'd4, 1, 0};
        tbl[8] = '{1, 6'd0, 6'd0, 1, 0, 0, 20'h00400, 6'd0, 0, 10'd0, 0, 1};
        tbl[9] = '{0, 6'd0, 6'd0, 1, 0, 0, 20'h00400, 6'd0, 0, 10'd0, 0, 0};

        reset = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].nn, tbl[i].n, tbl[i].d, tbl[i].pl, tbl[i].bt, tbl[i].gn, tbl[i].ss);
            check($sformatf("table[%0d]", i), 32'(dut_vec()),
                  32'({tbl[i].e_note, tbl[i].e_act, tbl[i].e_addr, tbl[i].e_valid,
                       tbl[i].e_done}));
        end

        // note 5, 3 beats, beat every 4 cycles: one done, right after the 3rd beat
        do_reset();
        cycle(1, 6'd5, 6'd3, 1, 0, 0, 20'h0);
        done_cnt = 0; done_at = -1; beat_no = 0; third_beat = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(0, 6'd0, 6'd0, 1, (i % 4 == 0), 0, 20'h0);
            if (i % 4 == 0) begin
                beat_no++;
                if (beat_no == 3) third_beat = i;
            end
            if (i == 11) check("active_during_note", 32'(note_active), 32'd1);
            if (i == 12) check("active_after_note", 32'(note_active), 32'd0);
            if (note_done) begin done_cnt++; done_at = i; end
        end
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_after_3rd_beat", 32'(done_at), 32'(third_beat));

        // Pause: beat every cycle, play low for cycles 2..11 -> done 10 cycles later
        for (int p = 0; p < 2; p++) begin
            do_reset();
            cycle(1, 6'd3, 6'd4, 1, 0, 0, 20'h0);
            done_at = -1;
            for (int i = 0; i < 16; i++) begin
                cycle(0, 6'd0, 6'd0, !(p == 1 && i >= 2 && i < 12), 1, 1, 20'h00400);
                if (p == 1 && i == 11) check("pause_addr_held", 32'(sample_addr), 32'd1);
                if (note_done && done_at < 0) done_at = i;
            end
            check(p ? "pause_done_cycle" : "nopause_done_cycle", 32'(done_at),
                  p ? 32'd13 : 32'd3);
        end

        // Zero-length note, then a rest of two beats
        do_reset();
        cycle(1, 6'd7, 6'd0, 1, 0, 0, 20'h0);
        check("zero_dur_done", 32'({note_done, note_active}), 32'b10);
        cycle(0, 6'd0, 6'd0, 1, 0, 0, 20'h0);
        check("zero_dur_single", 32'(note_done), 32'd0);
        cycle(1, 6'd0, 6'd2, 1, 0, 1, 20'h12345);
        cycle(0, 6'd0, 6'd0, 1, 1, 1, 20'h12345);
        cycle(0, 6'd0, 6'd0, 1, 1, 1, 20'h12345);
        check("rest_done", 32'({note_done, note_active, sample_addr}), 32'({1'b1, 1'b0, 10'd0}));

        // New note on the final beat of the previous one wins
        do_reset();
        cycle(1, 6'd4, 6'd1, 1, 0, 0, 20'h0);
        cycle(1, 6'd9, 6'd2, 1, 1, 0, 20'h0);
        check("overlap_no_done", 32'({note_done, note_q}), 32'({1'b0, 6'd9}));
        cycle(0, 6'd0, 6'd0, 1, 1, 0, 20'h0);
        check("overlap_restart_1", 32'(note_done), 32'd0);
        cycle(0, 6'd0, 6'd0, 1, 1, 0, 20'h0);
        check("overlap_restart_2", 32'(note_done), 32'd1);

        // Asynchronous reset between edges mid-note
        do_reset();
        cycle(1, 6'd6, 6'd5, 1, 0, 1, 20'h7FFFF);
        for (int i = 0; i < 3; i++) cycle(0, 6'd0, 6'd0, 1, 1, 1, 20'h7FFFF);
        @(negedge clk);
        #2 reset = 1;
        #1 check("async_reset_outputs", 32'(dut_vec()), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 6'd0, 6'd0, 1, 1, 0, 20'h0);
            if (note_done) done_cnt++;
        end
        check("no_done_after_reset", 32'(done_cnt), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(15) == 0),
                  ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom),
                  6'($urandom_range(7)),
                  ($urandom_range(9) < 8),
                  ($urandom_range(3) == 0),
                  $urandom_range(1) == 1,
                  20'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
